floor_request_queue: RTL and testbench
======================================

# floor_request_queue

Collects floor calls from the button panel and presents them to the elevator car controller as a pending-request bitmap, plus an empty flag and a recommended travel direction. Sits directly upstream of the car FSM. It consumes the car's current floor, direction and disembark indication, and clears each served floor's request.

## Interface

Parameters:
- NUM_FLOORS, 7, number of served floors; floors are indexed 0..NUM_FLOORS-1.
- SYNC_STAGES, 2, flip-flop stages in the button synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- call_req  in  NUM_FLOORS  raw, asynchronous, level button inputs, one per floor (hall and car buttons ORed externally).
- current_floor  in  3  floor the car currently occupies.
- current_up_ndown  in  1  car's present direction: 1 = up, 0 = down.
- deassert_floor  in  1  level; car is disembarking at current_floor.
- queue_status  out  NUM_FLOORS  pending-request bitmap; bit f set = floor f requested.
- queue_empty  out  1  high when queue_status is all zero.
- next_up_ndown  out  1  recommended next direction: 1 = up, 0 = down.
- pending_count  out  3  population count of queue_status.

## Operation

- Reset values: queue_status=0, queue_empty=1, next_up_ndown=0, pending_count=0. Synchronizer and edge-detect flops are cleared to 0.
- Each call_req bit passes through SYNC_STAGES flops, then a rising-edge detector. Only a 0→1 transition of the synchronized level produces a set pulse; holding a button produces one pulse.
  - A button that is already high when reset releases produces no pulse.
- Request bitmap, per floor f, each cycle:
  - Clear condition: deassert_floor=1 and current_floor==f.
  - Clear has priority over a simultaneous set pulse. The request is lost, because the car is already serving that floor.
  - Otherwise a set pulse sets bit f. Setting an already-set bit has no effect.
  - Otherwise the bit holds.
- deassert_floor is a level. Clearing repeats on every cycle it is high, so presses at the served floor during disembark are absorbed.
- current_floor values ≥ NUM_FLOORS are illegal. In that case nothing is cleared, and both the above and below masks are empty.
- queue_empty and pending_count are combinational from the queue_status register.
- Direction decision, registered each cycle from the current bitmap:
  - above = any bit set at index > current_floor; below = any bit set at index < current_floor.
  - above and below both set: next_up_ndown = current_up_ndown, so the car keeps its present sweep.
  - Only above set: 1.
  - Only below set: 0.
  - Neither set (empty, or only current_floor pending): hold the previous value.
  - At floor NUM_FLOORS-1, above is always empty. At floor 0, below is always empty.

## Timing

- call_req is high before edge N. With SYNC_STAGES=2, the final sync flop is 1 after edge N+1. The queue_status bit is 1 after edge N+2.
- queue_empty and pending_count change in the same cycle as queue_status.
- next_up_ndown reflects the new bitmap one edge later, after N+3.
- Clear: deassert_floor=1 with current_floor=f before edge M. Bit f is 0 after edge M, and next_up_ndown updates after M+1.
- call_req pulses shorter than one clk period may be missed. Buttons are slow, so this is acceptable.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and in-flight synchronizer contents are discarded.

## Structure

- Shared package elevator_pkg holds:
  - NUM_FLOORS;
  - typedef floor_t (logic [2:0]);
  - typedef floor_mask_t (logic [NUM_FLOORS-1:0]);
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
- Sub-module call_sync: a per-bit SYNC_STAGES synchronizer plus rising-edge detector, NUM_FLOORS wide, outputting a one-cycle set pulse vector.
- The bitmap, clear logic, above/below masks, direction register and popcount live in the top module.

## Test plan

- Reset, then call_req[4] held high from edge 0 with current_floor=0 → queue_status=7'b0010000 after edge 2; queue_empty=0; pending_count=1; next_up_ndown=1 after edge 3. Holding the button produces no further change.
- Pending {1,5}, current_floor=3, current_up_ndown=0 → next_up_ndown=0. Same bitmap with current_up_ndown=1 → next_up_ndown=1.
- Pending {2}, current_floor=2, deassert_floor=1 for 4 cycles while call_req[2] toggles → queue_status=0, queue_empty=1, next_up_ndown unchanged.
- Set pulse for floor 6 in the same cycle as deassert_floor=1 with current_floor=6 → bit 6 stays 0. The same pulse with current_floor=5 → bit 6 set.
- All seven floors pressed → pending_count=7. current_floor=7 with deassert_floor=1 → no bit cleared.
- Reset asserted with 3 requests pending and a press in the synchronizer → all outputs at reset values next cycle, and no late set pulse appears.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator types and constants used by the floor request queue and
// the car controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 7;

    typedef logic [2:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/floor_request_queue_if.sv
// Connection between the floor request queue and its neighbours:
// button panel and car controller on one side, queue on the other.
interface floor_request_queue_if;
    import elevator_pkg::*;

    floor_mask_t call_req;
    floor_t      current_floor;
    logic        current_up_ndown;
    logic        deassert_floor;
    floor_mask_t queue_status;
    logic        queue_empty;
    logic        next_up_ndown;
    logic [2:0]  pending_count;

    modport master (
        output call_req, current_floor, current_up_ndown, deassert_floor,
        input  queue_status, queue_empty, next_up_ndown, pending_count
    );

    modport slave (
        input  call_req, current_floor, current_up_ndown, deassert_floor,
        output queue_status, queue_empty, next_up_ndown, pending_count
    );
endinterface

// File: rtl/floor_request_queue_call_sync.sv
// Per-button synchronizer chain plus rising-edge detector producing one-cycle
// set pulses; edges are ignored until the chain has refilled after reset.
module call_sync #(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_set_pulse
);

    logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]     r_prev;
    logic [SYNC_STAGES:0] r_fill;
    logic [WIDTH-1:0]     w_sync_out;
    logic                 w_armed;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // Armed one cycle after the last stage first holds real data, so a button
    // already held at reset release loads r_prev without producing a pulse.
    assign w_armed    = r_fill[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_fill <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_out;
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign o_set_pulse = w_sync_out & ~r_prev & {WIDTH{w_armed}};

endmodule

// File: rtl/floor_request_queue.sv
// Pending floor-call bitmap with served-floor clearing, population count and
// a registered recommended travel direction for the car controller.
module floor_request_queue #(
    parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    floor_request_queue_if.slave    bus
);
    import elevator_pkg::*;

    localparam floor_t LAST_FLOOR = floor_t'(NUM_FLOORS - 1);

    logic [NUM_FLOORS-1:0] w_set_pulse;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [NUM_FLOORS-1:0] w_above_bits;
    logic [NUM_FLOORS-1:0] w_below_bits;
    logic [NUM_FLOORS-1:0] w_queue_next;
    logic [NUM_FLOORS-1:0] r_queue;
    logic                  r_next_dir;
    logic                  w_dir_next;
    logic                  w_floor_legal;
    logic [2:0]            w_count;

    call_sync #(
        .WIDTH       (NUM_FLOORS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_call_sync (
        .clk         (clk),
        .reset       (reset),
        .i_async     (bus.call_req),
        .o_set_pulse (w_set_pulse)
    );

    // An out-of-range floor matches no bit and contributes to neither mask.
    assign w_floor_legal = (bus.current_floor <= LAST_FLOOR);

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign w_clear[gi]      = bus.deassert_floor && (bus.current_floor == floor_t'(gi));
            assign w_above_bits[gi] = r_queue[gi] && w_floor_legal && (floor_t'(gi) > bus.current_floor);
            assign w_below_bits[gi] = r_queue[gi] && w_floor_legal && (floor_t'(gi) < bus.current_floor);
        end
    endgenerate

    // Clearing wins: a press at the floor being served is absorbed.
    assign w_queue_next = (r_queue | w_set_pulse) & ~w_clear;

    always_comb begin
        w_dir_next = r_next_dir;
        if ((|w_above_bits) && (|w_below_bits)) begin
            w_dir_next = bus.current_up_ndown;
        end else if (|w_above_bits) begin
            w_dir_next = DIR_UP;
        end else if (|w_below_bits) begin
            w_dir_next = DIR_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_queue    <= '0;
            r_next_dir <= DIR_DOWN;
        end else begin
            r_queue    <= w_queue_next;
            r_next_dir <= w_dir_next;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_count = w_count + {2'b00, r_queue[i]};
        end
    end

    assign bus.queue_status  = r_queue;
    assign bus.queue_empty   = ~(|r_queue);
    assign bus.next_up_ndown = r_next_dir;
    assign bus.pending_count = w_count;

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue: hand-computed expectations for
// set/clear timing, direction choice, absorption and reset behaviour.
module tb_floor_request_queue;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    floor_request_queue_if bus();

    floor_request_queue #(
        .NUM_FLOORS  (7),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.call_req         = '0;
        bus.current_floor    = 3'd0;
        bus.current_up_ndown = 1'b0;
        bus.deassert_floor   = 1'b0;
        reset                = 1'b1;
        tick();
        tick();
        check("rst_queue", 32'(bus.queue_status), 32'h00);
        check("rst_empty", 32'(bus.queue_empty), 32'h1);
        check("rst_dir",   32'(bus.next_up_ndown), 32'h0);
        check("rst_count", 32'(bus.pending_count), 32'h0);
        reset = 1'b0;
        repeat (4) tick();

        // Floor 4 pressed with car at floor 0
        bus.call_req[4] = 1'b1;
        tick();
        tick();
        check("f4_e1_queue", 32'(bus.queue_status), 32'h00);
        tick();
        check("f4_e2_queue", 32'(bus.queue_status), 32'h10);
        check("f4_e2_empty", 32'(bus.queue_empty), 32'h0);
        check("f4_e2_count", 32'(bus.pending_count), 32'h1);
        check("f4_e2_dir",   32'(bus.next_up_ndown), 32'h0);
        tick();
        check("f4_e3_dir",   32'(bus.next_up_ndown), 32'h1);
        repeat (6) tick();
        check("f4_hold_queue", 32'(bus.queue_status), 32'h10);
        check("f4_hold_count", 32'(bus.pending_count), 32'h1);

        bus.call_req       = '0;
        bus.current_floor  = 3'd4;
        bus.deassert_floor = 1'b1;
        tick();
        bus.deassert_floor = 1'b0;
        check("f4_clear_queue", 32'(bus.queue_status), 32'h00);
        tick();
        check("empty_dir_hold", 32'(bus.next_up_ndown), 32'h1);

        // Requests above and below: sweep direction follows the car
        bus.current_floor    = 3'd3;
        bus.current_up_ndown = 1'b0;
        bus.call_req         = 7'b0100010;
        repeat (3) tick();
        tick();
        check("both_queue",   32'(bus.queue_status), 32'h22);
        check("both_dir_dn",  32'(bus.next_up_ndown), 32'h0);
        bus.current_up_ndown = 1'b1;
        tick();
        check("both_dir_up",  32'(bus.next_up_ndown), 32'h1);
        bus.call_req       = '0;
        bus.deassert_floor = 1'b1;
        bus.current_floor  = 3'd1;
        tick();
        bus.current_floor  = 3'd5;
        tick();
        bus.deassert_floor = 1'b0;
        check("both_cleared", 32'(bus.queue_status), 32'h00);

        // Floor 2 pending, car arrives and disembarks while button toggles
        bus.current_floor = 3'd3;
        bus.call_req[2]   = 1'b1;
        repeat (4) tick();
        check("f2_queue",     32'(bus.queue_status), 32'h04);
        check("f2_dir_below", 32'(bus.next_up_ndown), 32'h0);
        bus.current_floor  = 3'd2;
        bus.deassert_floor = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.call_req[2] = (i == 0) || (i == 2);
            tick();
        end
        check("f2_absorb_queue", 32'(bus.queue_status), 32'h00);
        check("f2_absorb_empty", 32'(bus.queue_empty), 32'h1);
        check("f2_absorb_dir",   32'(bus.next_up_ndown), 32'h0);
        bus.deassert_floor = 1'b0;
        bus.call_req       = '0;
        repeat (4) tick();
        check("f2_no_late_set", 32'(bus.queue_status), 32'h00);

        // Floor 6 pulse coinciding with a clear at floor 6, then at floor 5
        bus.current_floor  = 3'd6;
        bus.deassert_floor = 1'b1;
        bus.call_req[6]    = 1'b1;
        repeat (4) tick();
        check("f6_clear_wins", 32'(bus.queue_status), 32'h00);
        bus.deassert_floor = 1'b0;
        tick();
        check("f6_still_clear", 32'(bus.queue_status), 32'h00);
        bus.call_req = '0;
        repeat (3) tick();
        bus.current_floor  = 3'd5;
        bus.deassert_floor = 1'b1;
        bus.call_req[6]    = 1'b1;
        repeat (3) tick();
        check("f6_other_floor", 32'(bus.queue_status), 32'h40);
        tick();
        check("f6_dir_up", 32'(bus.next_up_ndown), 32'h1);
        bus.deassert_floor = 1'b0;
        bus.call_req       = '0;
        repeat (2) tick();

        // All floors pressed, then an illegal floor with deassert
        bus.call_req = 7'h7F;
        repeat (3) tick();
        check("all_queue", 32'(bus.queue_status), 32'h7F);
        check("all_count", 32'(bus.pending_count), 32'h7);
        check("all_empty", 32'(bus.queue_empty), 32'h0);
        bus.current_up_ndown = 1'b0;
        bus.current_floor    = 3'd7;
        bus.deassert_floor   = 1'b1;
        repeat (2) tick();
        check("illegal_queue", 32'(bus.queue_status), 32'h7F);
        check("illegal_count", 32'(bus.pending_count), 32'h7);
        check("illegal_dir",   32'(bus.next_up_ndown), 32'h1);
        bus.call_req = '0;

        // Leave {4,5,6} pending, then reset with a press in flight
        for (int f = 0; f < 4; f++) begin
            bus.current_floor = 3'(f);
            tick();
        end
        bus.deassert_floor = 1'b0;
        check("pre_rst_queue", 32'(bus.queue_status), 32'h70);
        check("pre_rst_count", 32'(bus.pending_count), 32'h3);
        bus.current_floor = 3'd0;
        repeat (2) tick();
        check("pre_rst_dir", 32'(bus.next_up_ndown), 32'h1);
        bus.call_req[1] = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_queue", 32'(bus.queue_status), 32'h00);
        check("mid_rst_empty", 32'(bus.queue_empty), 32'h1);
        check("mid_rst_count", 32'(bus.pending_count), 32'h0);
        check("mid_rst_dir",   32'(bus.next_up_ndown), 32'h0);
        reset = 1'b0;
        repeat (8) tick();
        check("post_rst_queue", 32'(bus.queue_status), 32'h00);
        check("post_rst_count", 32'(bus.pending_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
